mult_div_unit: RTL and testbench

- Sequential signed multiply/divide unit for the multicycle CPU datapath.
- Produces the HI/LO pair consumed by the downstream 4:1 32-bit write-back/operand select mux. HI and LO are two of its four inputs.
- Control FSM issues a start pulse and waits for done before selecting HI or LO.
- Iterative design: one bit per cycle; no combinational multiplier.

---
 rtl/mult_div_pkg.sv | 31 +++
 rtl/mult_div_unit_div_restore_step.sv | 37 +++
 rtl/mult_div_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the sequential multiply/divide unit.
//   state_e    : control FSM states (IDLE, MULT, DIV, FIX, DONE)
//   OP_MULT/DIV: encoding of the 'op' input
//   cnt_width(): iteration counter width for a given operand width
//   CNT_W      : counter width for the default 32-bit operand width
// ---------------------------------------------------------------------------
package mult_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_WIDTH = 32;

  // Counter must hold 0 .. WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One combinational iteration of restoring division on magnitudes.
// Ports:
//   rem_i [WIDTH-1:0] : current partial remainder (always < div_i)
//   bit_i             : next dividend bit, shifted into the remainder
//   div_i [WIDTH-1:0] : divisor magnitude (non-zero)
//   rem_o [WIDTH-1:0] : next partial remainder
//   q_o               : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction one bit wider than the operands; bit WIDTH of the
  // difference is set exactly when the shifted remainder is below the divisor.
  always_comb begin
    trial_s = {rem_i, bit_i};
    diff_s  = trial_s - {1'b0, div_i};
    q_o     = ~diff_s[WIDTH];
    if (q_o) begin
      rem_o = diff_s[WIDTH-1:0];
    end else begin
      rem_o = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative signed multiply / divide unit producing a HI/LO pair.
// Multiply: radix-2 Booth, one bit per cycle (done in cycle WIDTH+1).
// Divide  : restoring division on magnitudes plus one sign-fix cycle
//           (done in cycle WIDTH+2); divide by zero finishes in cycle 1
//           with div_zero=1 and HI/LO untouched.
// Optional build macro MULT_DIV_UNSIGNED_EN adds op_unsigned (multu/divu).
// Ports:
//   clk, reset_n  : clock (rising edge), asynchronous active-low reset
//   start, op     : one-cycle request accepted in IDLE; op 0=mult, 1=div
//   op_unsigned   : (MULT_DIV_UNSIGNED_EN only) treat operands as unsigned
//   a, b          : operands, captured on the accepting edge
//   busy          : high in every non-IDLE state (including DONE)
//   done          : one-cycle completion pulse
//   div_zero      : division by zero flag, held until the next accepted start
//   hi, lo        : mult: product high/low; div: remainder/quotient
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             uns_q, uns_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  // Multiplicand (mult) or divisor magnitude (div).
  logic [WIDTH-1:0] m_q, m_d;
  // Booth multiplier/low product (mult) or dividend/quotient shift register (div).
  logic [WIDTH-1:0] wlo_q, wlo_d;
  // Booth accumulator (mult); its low WIDTH bits hold the partial remainder (div).
  logic [WIDTH+1:0] acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             uns_s;
  logic [WIDTH+1:0] m_ext_s, booth_sum_s, booth_acc_s;
  logic [WIDTH-1:0] booth_lo_s, booth_hi_s;
  logic [WIDTH-1:0] div_rem_s;
  logic             div_q_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns_s = op_unsigned;
`else
  assign uns_s = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    if (is_signed && x[WIDTH-1]) begin
      return neg2(x);
    end else begin
      return x;
    end
  endfunction

  // Booth step: two guard bits keep the accumulator exact even for the most
  // negative multiplicand and for zero-extended unsigned multiplicands.
  always_comb begin
    if (uns_q) begin
      m_ext_s = {2'b00, m_q};
    end else begin
      m_ext_s = {{2{m_q[WIDTH-1]}}, m_q};
    end
    case ({wlo_q[0], qm1_q})
      2'b01:   booth_sum_s = acc_q + m_ext_s;
      2'b10:   booth_sum_s = acc_q - m_ext_s;
      default: booth_sum_s = acc_q;
    endcase
    booth_acc_s = {booth_sum_s[WIDTH+1], booth_sum_s[WIDTH+1:1]};
    booth_lo_s  = {booth_sum_s[0], wlo_q[WIDTH-1:1]};
    // Booth reads the multiplier as signed; an unsigned multiplier with its
    // MSB set is short by multiplicand * 2^WIDTH, added back into HI.
    if (uns_q && sb_q) begin
      booth_hi_s = booth_acc_s[WIDTH-1:0] + m_q;
    end else begin
      booth_hi_s = booth_acc_s[WIDTH-1:0];
    end
  end

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .bit_i (wlo_q[WIDTH-1]),
    .div_i (m_q),
    .rem_o (div_rem_s),
    .q_o   (div_q_s)
  );

  // Sign correction: quotient negative when operand signs differ, remainder
  // follows the dividend; this truncates the quotient toward zero.
  always_comb begin
    if (!uns_q && (sa_q ^ sb_q)) begin
      fix_lo_s = neg2(wlo_q);
    end else begin
      fix_lo_s = wlo_q;
    end
    if (!uns_q && sa_q) begin
      fix_hi_s = neg2(acc_q[WIDTH-1:0]);
    end else begin
      fix_hi_s = acc_q[WIDTH-1:0];
    end
  end

  // Control FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    m_d     = m_q;
    wlo_d   = wlo_q;
    acc_d   = acc_q;
    qm1_d   = qm1_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          uns_d = uns_s;
          sa_d  = a[WIDTH-1];
          sb_d  = b[WIDTH-1];
          dz_d  = 1'b0;
          if (op == OP_DIV) begin
            if (b == '0) begin
              state_d = DONE;
              dz_d    = 1'b1;
            end else begin
              state_d = DIV;
              m_d     = mag(b, !uns_s);
              wlo_d   = mag(a, !uns_s);
            end
          end else begin
            state_d = MULT;
            m_d     = a;
            wlo_d   = b;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d = booth_acc_s;
        wlo_d = booth_lo_s;
        qm1_d = wlo_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          hi_d    = booth_hi_s;
          lo_d    = booth_lo_s;
        end else begin
          state_d = MULT;
        end
      end
      DIV: begin
        acc_d = {2'b00, div_rem_s};
        wlo_d = {wlo_q[WIDTH-2:0], div_q_s};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          state_d = DIV;
        end
      end
      FIX: begin
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      wlo_q   <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      m_q     <= m_d;
      wlo_q   <= wlo_d;
      acc_q   <= acc_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit: expected HI/LO/div_zero/latency are
// computed from operands and pushed to a queue at issue, popped at done.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned (1'b0),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p     = sx * sy;
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dz  = 1'b0;
      e.lat = 33;
    end else if (y == 32'h0) begin
      e.hi  = model_hi;
      e.lo  = model_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q     = sx / sy;
      r     = sx % sy;
      e.hi  = r[31:0];
      e.lo  = q[31:0];
      e.dz  = 1'b0;
      e.lat = 34;
    end
    return e;
  endfunction

  // Issue one operation (called #1 after a rising edge with the unit idle)
  // and follow it to completion. With inject set, ignored start pulses are
  // driven in cycle 10 and in the done cycle.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit inject);
    exp_t e, got;
    int   n;
    e = model(o, x, y);
    sb_q.push_back(e);
    if (!e.dz) begin
      model_hi = e.hi;
      model_lo = e.lo;
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n     = 1;
    if (e.lat > 1) check("dz_clear_on_start", {31'd0, div_zero}, 32'd0);
    while (n <= 60) begin
      check("busy", {31'd0, busy}, 32'd1);
      if (done === 1'b1) break;
      if (inject && n == 10) begin
        start = 1'b1;
        op    = 1'b1;
        b     = 32'h0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(e.lat));
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check("hi", hi, got.hi);
      check("lo", lo, got.lo);
      check("div_zero", {31'd0, div_zero}, {31'd0, got.dz});
    end
    if (inject) begin
      start = 1'b1;
      op    = 1'b1;
      b     = 32'h0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("hi_hold", hi, e.hi);
  endtask

  initial begin
    // Reset state.
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Multiply 7 * -3 with ignored start pulses while busy and in done cycle.
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b1);
    // Most negative squared.
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0);
    run_op(1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0);
    run_op(1'b0, 32'h12345678, 32'hFEDCBA98, 1'b0);
    run_op(1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, $urandom, $urandom, 1'b0);
    end

    // Divides.
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(1'b1, 32'd3, 32'd10, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, $urandom, $urandom_range(1, 32'h0000FFFF), 1'b0);
    end

    // Divide by zero keeps HI/LO, then a multiply clears div_zero.
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    check("dz_held_idle", {31'd0, div_zero}, 32'd1);
    run_op(1'b0, 32'd9, 32'd9, 1'b0);

    // Reset in cycle 15 of a divide aborts with no done pulse.
    start = 1'b1;
    op    = 1'b1;
    a     = 32'hFFFFFC18;
    b     = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_dz", {31'd0, div_zero}, 32'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      check("post_abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op(1'b1, 32'hFFFFFC18, 32'd7, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
